// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling-free UART receiver with a one-entry holding register.
//
// The serial line is brought into the clk_i domain through a two-flop
// synchronizer. A falling edge on the synchronized line starts a frame. The
// start bit is re-checked at its middle so that short glitches are rejected.
// Every following bit is then sampled one bit period later, which places each
// sample near the middle of its bit.
//
// Frame format: start (0), 8 data bits LSB first, optional even parity, and
// stop (1).
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 11-bit frames with an even-parity bit;
//                                   parity_err_o is live.
//                      undefined -> 10-bit frames; the PARITY state is never
//                                   entered and parity_err_o is tied to 0.
//
// Parameters:
//   CLK_FREQ   clk_i frequency in Hz
//   BAUD_RATE  serial bit rate
//
// Ports:
//   clk_i         in   single clock, rising edge
//   rst_i         in   synchronous active-high reset
//   uart_rx_i     in   asynchronous serial line, idles high
//   rx_data_o     out  received byte (held until it is consumed)
//   rx_valid_o    out  rx_data_o holds an unconsumed byte
//   rx_ready_i    in   consumer takes the byte when rx_valid_o && rx_ready_i
//   frame_err_o   out  one-cycle pulse: stop bit sampled low
//   parity_err_o  out  one-cycle pulse: even-parity mismatch
//   overrun_o     out  one-cycle pulse: new byte dropped, holding register full
//   busy_o        out  receiver is inside a frame (any state but IDLE)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  // Timer compare values; the timer counts from 0 to N-1.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity: the transmitted parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic        sync1_q, sync2_q, prev_q;
  logic        rx_s, fall_s;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;

  logic        deliver_s;
  logic        frame_bad_s;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        busy_q, busy_d;

`ifdef UART_RX_PARITY_EN
  logic        par_mis_q, par_mis_d;
  logic        parity_bad_s;
  logic        perr_q, perr_d;
`endif

  // ---------------------------------------------------------------------------
  // Line synchronizer and edge detect
  // ---------------------------------------------------------------------------
  // The flops reset to the idle level (1) so that a reset never manufactures
  // a falling edge on a line that is already idle.
  // Synchronize the serial line and keep the previous synchronized sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s   = sync2_q;
  // A falling edge is 1 then 0. A line held low therefore yields one edge only.
  assign fall_s = prev_q & ~sync2_q;

  // ---------------------------------------------------------------------------
  // Frame FSM: state, bit timer, bit index and shift register
  // ---------------------------------------------------------------------------
  // FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity-mismatch flag; it lives from the PARITY sample to the STOP decision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_mis_q <= 1'b0;
    end else begin
      par_mis_q <= par_mis_d;
    end
  end
`endif

  // Next-state logic. The timer free-runs in every active state and is
  // cleared at each sample point.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 16'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver_s   = 1'b0;
    frame_bad_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_d    = par_mis_q;
    parity_bad_s = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (fall_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (timer_q == HALF_LAST) begin
          // Middle of the start bit: a high line here was only a glitch.
          if (rx_s) begin
            state_d = IDLE;
            timer_d = 16'd0;
          end else begin
            state_d = DATA;
            timer_d = 16'd0;
            idx_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_mis_d = 1'b0;
`endif
          end
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d        = 16'd0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = 16'd0;
          par_mis_d = (rx_s != even_parity(shift_q));
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif

      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = 16'd0;
          state_d = IDLE;
          // A frame error takes priority over a parity error; each frame
          // produces at most one outcome.
          if (!rx_s) begin
            frame_bad_s = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_mis_q) begin
            parity_bad_s = 1'b1;
`endif
          end else begin
            deliver_s = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding register and status outputs (all registered)
  // ---------------------------------------------------------------------------
  // Output next-state logic: a delivery into a full register that is not being
  // drained at the same time keeps the old byte and flags an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    ferr_d  = frame_bad_s;
    busy_d  = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
    perr_d  = parity_bad_s;
`endif

    if (deliver_s) begin
      if (valid_q && !rx_ready_i) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity-error pulse register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at default parameters.
//
// A negedge monitor keeps running totals of valid cycles, handshakes (with the
// accepted bytes), and error and overrun pulse cycles. Each check compares how
// much a total moved across one frame with the outcome predicted by a small
// frame model. The parity bit is sent only when UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 434;  // 50 MHz / 115200
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic       clk        = 1'b0;
  logic       rst_i      = 1'b1;
  logic       uart_rx_i  = 1'b1;
  logic       rx_ready_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  // Monitor totals
  int         valid_cycles = 0;
  int         ferr_cnt     = 0;
  int         perr_cnt     = 0;
  int         ovr_cnt      = 0;
  int         acc_n        = 0;
  logic [7:0] acc_mem [0:255];

  uart_rx dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .uart_rx_i    (uart_rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #10 clk = ~clk;

  // Sample the outputs half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (rx_valid_o)   valid_cycles <= valid_cycles + 1;
      if (frame_err_o)  ferr_cnt     <= ferr_cnt + 1;
      if (parity_err_o) perr_cnt     <= perr_cnt + 1;
      if (overrun_o)    ovr_cnt      <= ovr_cnt + 1;
      if (rx_valid_o && rx_ready_i) begin
        acc_mem[acc_n] <= rx_data_o;
        acc_n          <= acc_n + 1;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx_i = b;
    wait_clks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PARITY_EN) drive_bit(pbit);
    drive_bit(stop);
    uart_rx_i = 1'b1;
  endtask

  // Frame model. Stop low gives a frame error. Otherwise, when parity is
  // enabled, an odd total of ones over data and parity gives a parity error.
  // Anything else delivers the byte.
  function automatic void model(input logic [7:0] d, input logic stop, input logic pbit,
                                output int del, output int ferr, output int perr);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    del = 0; ferr = 0; perr = 0;
    if (!stop) ferr = 1;
    else if (PARITY_EN && ((ones % 2) != int'(pbit))) perr = 1;
    else del = 1;
  endfunction

  // Send one frame with rx_ready_i=1, then compare how far each total moved.
  task automatic frame_check(input logic [7:0] d, input logic stop, input logic pbit,
                             input int exp_del, input logic [7:0] exp_data,
                             input int exp_ferr, input int exp_perr, input int gap);
    int v0 = valid_cycles;
    int f0 = ferr_cnt;
    int p0 = perr_cnt;
    int o0 = ovr_cnt;
    int a0 = acc_n;
    send_frame(d, stop, pbit);
    wait_clks(gap);
    check("valid_cycles", valid_cycles - v0, exp_del);
    check("accepted",     acc_n - a0,        exp_del);
    if (acc_n - a0 == 1 && exp_del == 1) check("rx_data", int'(acc_mem[a0]), int'(exp_data));
    check("frame_err_pulses",  ferr_cnt - f0, exp_ferr);
    check("parity_err_pulses", perr_cnt - p0, exp_perr);
    check("overrun_pulses",    ovr_cnt - o0,  0);
    check("busy_after_frame",  int'(busy_o),  0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pbit;
    int         exp_del;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int v0, f0, p0, o0, a0;
    logic [7:0] rd;
    logic rs, rp;
    int m_del, m_ferr, m_perr;

    // Table: data, stop, parity bit, expected delivery, data, frame err, parity err
    vecs.push_back(vec_t'{8'h55, 1'b1, 1'b0, 1, 8'h55, 0, 0});
    vecs.push_back(vec_t'{8'hA3, 1'b0, 1'b0, 0, 8'h00, 1, 0});
    vecs.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0});
    vecs.push_back(vec_t'{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0, 0});
    vecs.push_back(vec_t'{8'hC4, 1'b1, 1'b1, 1, 8'hC4, 0, 0});
    if (PARITY_EN) begin
      vecs.push_back(vec_t'{8'h07, 1'b1, 1'b1, 1, 8'h07, 0, 0});
      vecs.push_back(vec_t'{8'h07, 1'b1, 1'b0, 0, 8'h00, 0, 1});
    end

    // Reset state
    wait_clks(5);
    check("reset_valid",  int'(rx_valid_o),   0);
    check("reset_data",   int'(rx_data_o),    0);
    check("reset_busy",   int'(busy_o),       0);
    check("reset_ferr",   int'(frame_err_o),  0);
    check("reset_perr",   int'(parity_err_o), 0);
    check("reset_ovr",    int'(overrun_o),    0);
    rst_i = 1'b0;
    wait_clks(10);

    // Table-driven frames
    foreach (vecs[k]) begin
      frame_check(vecs[k].data, vecs[k].stop, vecs[k].pbit, vecs[k].exp_del,
                  vecs[k].exp_data, vecs[k].exp_ferr, vecs[k].exp_perr, 20);
    end

    // Low glitch of 100 clocks on an idle line
    v0 = valid_cycles; f0 = ferr_cnt; p0 = perr_cnt; o0 = ovr_cnt;
    uart_rx_i = 1'b0;
    wait_clks(100);
    check("glitch_busy_during", int'(busy_o), 1);
    uart_rx_i = 1'b1;
    wait_clks(300);
    check("glitch_busy_after", int'(busy_o), 0);
    check("glitch_valid",  valid_cycles - v0, 0);
    check("glitch_errors", (ferr_cnt - f0) + (perr_cnt - p0) + (ovr_cnt - o0), 0);

    // Overrun: not ready, send 0x11 then 0x22
    rx_ready_i = 1'b0;
    o0 = ovr_cnt; a0 = acc_n;
    send_frame(8'h11, 1'b1, 1'b0);
    wait_clks(20);
    check("hold_valid", int'(rx_valid_o), 1);
    check("hold_data",  int'(rx_data_o),  8'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_clks(20);
    check("overrun_pulses", ovr_cnt - o0, 1);
    check("overrun_data",   int'(rx_data_o), 8'h11);
    check("overrun_valid",  int'(rx_valid_o), 1);
    check("overrun_no_accept", acc_n - a0, 0);
    rx_ready_i = 1'b1;
    wait_clks(2);
    check("drain_valid",    int'(rx_valid_o), 0);
    check("drain_accepted", acc_n - a0, 1);
    check("drain_data",     int'(acc_mem[a0]), 8'h11);

    // Reset during D3, with a byte still held
    rx_ready_i = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_clks(20);
    check("pre_reset_valid", int'(rx_valid_o), 1);
    drive_bit(1'b0);              // start
    drive_bit(1'b0);              // D0 of 0x3C
    drive_bit(1'b0);              // D1
    drive_bit(1'b1);              // D2
    uart_rx_i = 1'b1;             // D3
    wait_clks(200);
    rst_i = 1'b1;
    wait_clks(1);
    check("midreset_valid", int'(rx_valid_o),   0);
    check("midreset_data",  int'(rx_data_o),    0);
    check("midreset_busy",  int'(busy_o),       0);
    check("midreset_errs",  int'(frame_err_o) + int'(parity_err_o) + int'(overrun_o), 0);
    rst_i = 1'b0;
    rx_ready_i = 1'b1;
    v0 = valid_cycles; f0 = ferr_cnt;
    wait_clks(2 * CPB);
    check("post_reset_idle_busy",  int'(busy_o), 0);
    check("post_reset_idle_valid", valid_cycles - v0, 0);
    check("post_reset_idle_ferr",  ferr_cnt - f0, 0);
    frame_check(8'h3C, 1'b1, 1'b0, 1, 8'h3C, 0, 0, 20);

    // Randomized frames checked against the frame model
    for (int n = 0; n < 5; n++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
      model(rd, rs, rp, m_del, m_ferr, m_perr);
      frame_check(rd, rs, rp, m_del, rd, m_ferr, m_perr, 4 + int'($urandom_range(0, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
